// File: rtl/csm_dual_port_ctrl.sv
// Two-port byte memory with one shared hold/release lock; each port runs its own request FSM.
// Latency: command accepted at edge N, completes at N+1 (ack low for one cycle, err/out_data update at N+1).
// Backpressure: ack=0 while busy; enable is ignored outside IDLE; ports never stall each other.
module csm_dual_port_ctrl #(
    parameter int DATABITS = 8,
    parameter int ERRBITS  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATABITS-1:0] A_in_AD,
    input  logic                A_rw,
    input  logic                A_enable,
    input  logic                A_hold,
    input  logic                A_release,
    output logic                A_ack,
    output logic [ERRBITS-1:0]  A_err,
    output logic [DATABITS-1:0] A_out_data,
    input  logic [DATABITS-1:0] B_in_AD,
    input  logic                B_rw,
    input  logic                B_enable,
    input  logic                B_hold,
    input  logic                B_release,
    output logic                B_ack,
    output logic [ERRBITS-1:0]  B_err,
    output logic [DATABITS-1:0] B_out_data
);
    localparam int DEPTH = 2 ** DATABITS;
    localparam logic [ERRBITS-1:0] ERR_OK        = ERRBITS'(0);
    localparam logic [ERRBITS-1:0] ERR_LOCKED    = ERRBITS'(1);
    localparam logic [ERRBITS-1:0] ERR_NOT_OWNER = ERRBITS'(2);
    localparam logic [ERRBITS-1:0] ERR_COLLIDE   = ERRBITS'(3);

    typedef enum logic [1:0] {IDLE, RD, WR, LK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

    logic [DATABITS-1:0] in_ad [2];
    logic [1:0]          enable, rw, hold, rel;

    assign in_ad[0] = A_in_AD;
    assign in_ad[1] = B_in_AD;
    assign enable   = {B_enable, A_enable};
    assign rw       = {B_rw, A_rw};
    assign hold     = {B_hold, A_hold};
    assign rel      = {B_release, A_release};

    state_t              state_q [2];
    state_t              state_d [2];
    logic [DATABITS-1:0] addr_q  [2];
    logic [1:0]          rel_q, blocked_q;
    owner_t              owner_q, owner_d;
    logic [ERRBITS-1:0]  err_q   [2];
    logic [ERRBITS-1:0]  err_d   [2];
    logic [DATABITS-1:0] data_q  [2];
    logic [DATABITS-1:0] data_d  [2];
    logic [1:0]          wr_en;
    logic [DATABITS-1:0] mem     [DEPTH];

    function automatic owner_t self_id(input int p);
        return (p == 0) ? OWN_A : OWN_B;
    endfunction

    function automatic owner_t other_id(input int p);
        return (p == 0) ? OWN_B : OWN_A;
    endfunction

    // Ports are evaluated A then B so that A wins a simultaneous hold.
    always_comb begin
        owner_d = owner_q;
        wr_en   = '0;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            err_d[p]   = err_q[p];
            data_d[p]  = data_q[p];
        end
        for (int p = 0; p < 2; p++) begin
            case (state_q[p])
                IDLE: begin
                    if (enable[p]) begin
                        if (hold[p] || rel[p]) state_d[p] = LK;
                        else if (rw[p])        state_d[p] = WR;
                        else                   state_d[p] = RD;
                    end
                end
                RD: begin
                    state_d[p] = IDLE;
                    if (blocked_q[p]) begin
                        err_d[p]  = ERR_LOCKED;
                        data_d[p] = '0;
                    end else begin
                        err_d[p]  = ERR_OK;
                        data_d[p] = mem[addr_q[p]];
                    end
                end
                WR: begin
                    state_d[p] = IDLE;
                    if (blocked_q[p]) begin
                        err_d[p] = ERR_LOCKED;
                    end else begin
                        err_d[p] = ERR_OK;
                        wr_en[p] = 1'b1;
                    end
                end
                LK: begin
                    state_d[p] = IDLE;
                    if (!rel_q[p]) begin
                        if (owner_d == OWN_NONE || owner_d == self_id(p)) begin
                            owner_d  = self_id(p);
                            err_d[p] = ERR_OK;
                        end else begin
                            err_d[p] = ERR_LOCKED;
                        end
                    end else if (owner_d == self_id(p)) begin
                        owner_d  = OWN_NONE;
                        err_d[p] = ERR_OK;
                    end else begin
                        err_d[p] = ERR_NOT_OWNER;
                    end
                end
                default: state_d[p] = IDLE;
            endcase
        end
        if (wr_en[0] && wr_en[1] && (addr_q[0] == addr_q[1])) begin
            wr_en[1] = 1'b0;
            err_d[1] = ERR_COLLIDE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= OWN_NONE;
            rel_q     <= '0;
            blocked_q <= '0;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                addr_q[p]  <= '0;
                err_q[p]   <= '0;
                data_q[p]  <= '0;
            end
        end else begin
            owner_q <= owner_d;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                err_q[p]   <= err_d[p];
                data_q[p]  <= data_d[p];
                // Lock ownership for reads/writes is frozen at accept time.
                if (state_q[p] == IDLE && enable[p]) begin
                    addr_q[p]    <= in_ad[p];
                    rel_q[p]     <= !hold[p] && rel[p];
                    blocked_q[p] <= (owner_q == other_id(p));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en[0]) mem[addr_q[0]] <= in_ad[0];
            if (wr_en[1]) mem[addr_q[1]] <= in_ad[1];
        end
    end

    assign A_ack      = (state_q[0] == IDLE);
    assign B_ack      = (state_q[1] == IDLE);
    assign A_err      = err_q[0];
    assign B_err      = err_q[1];
    assign A_out_data = data_q[0];
    assign B_out_data = data_q[1];
endmodule
